multi_cache: RTL and testbench

//  Parameterised set-associative L1 data cache: 8 sets x WAY_COUNT ways x 32-byte lines, 11-bit byte address.

---
 rtl/multi_cache.sv | 142 ++++++++++++++
 tb/tb_multi_cache.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cache.sv
// Set-associative L1 data cache: 8 sets x WAY_COUNT ways x 32-byte lines, one access per clock.
// A miss fills the whole line from iRAM32 in the same edge; LRU or LFSR-random victim choice.
module multi_cache #(
  parameter int WAY_COUNT              = 2,
  parameter bit USE_RANDOM_REPLACEMENT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivalid,
  input  logic            iRW,
  input  logic [10:0]     iaddress,
  input  logic [31:0][7:0] iRAM32,
  input  logic [7:0]      iwrite_data,
  output logic            L1miss,
  output logic            ovalid,
  output logic [7:0]      oread_data,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     total_accesses
);

  // Handshake: ivalid qualifies one access per rising edge and there is no backpressure;
  // ovalid pulses for exactly one cycle, the cycle after the access edge, with L1miss/oread_data.

  localparam int WB = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
  typedef logic [WB-1:0] way_t;

  logic [WAY_COUNT-1:0] valid_q [8], valid_d [8];
  logic [2:0]           tag_q   [8][WAY_COUNT], tag_d  [8][WAY_COUNT];
  logic [31:0][7:0]     data_q  [8][WAY_COUNT], data_d [8][WAY_COUNT];
  way_t                 age_q   [8][WAY_COUNT], age_d  [8][WAY_COUNT];
  logic [7:0]           lfsr_q, lfsr_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, total_q, total_d;
  logic                 l1miss_q, l1miss_d, ovalid_q, ovalid_d;
  logic [7:0]           rdata_q, rdata_d;

  logic [2:0] set_idx, tag_in;
  logic [4:0] offset;
  logic       hit, has_free;
  way_t       hit_way, free_way, lru_way, rand_way, victim, acc_way;

  // Lookup: the descending loop leaves the lowest-numbered free way in free_way.
  always_comb begin
    set_idx  = iaddress[7:5];
    tag_in   = iaddress[10:8];
    offset   = iaddress[4:0];
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    lru_way  = '0;
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_free = 1'b1;
        free_way = way_t'(w);
      end
      if (age_q[set_idx][w] == way_t'(WAY_COUNT - 1)) lru_way = way_t'(w);
    end
    rand_way = (WAY_COUNT == 1) ? '0 : lfsr_q[WB-1:0];
    victim   = has_free ? free_way : (USE_RANDOM_REPLACEMENT ? rand_way : lru_way);
    acc_way  = hit ? hit_way : victim;
  end

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    age_d      = age_q;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    total_d    = total_q;
    l1miss_d   = l1miss_q;
    rdata_d    = rdata_q;
    ovalid_d   = 1'b0;
    if (ivalid) begin
      if (!hit) begin
        valid_d[set_idx][acc_way] = 1'b1;
        tag_d[set_idx][acc_way]   = tag_in;
        data_d[set_idx][acc_way]  = iRAM32;
      end
      if (iRW) begin
        data_d[set_idx][acc_way][offset] = iwrite_data;
        rdata_d                          = iwrite_data;
      end else begin
        rdata_d = hit ? data_q[set_idx][acc_way][offset] : iRAM32[offset];
      end
      // Ages form a permutation per set; ways younger than the accessed one grow older by one.
      if (!USE_RANDOM_REPLACEMENT) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
          if (age_q[set_idx][w] < age_q[set_idx][acc_way]) age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
        end
        age_d[set_idx][acc_way] = '0;
      end
      total_d    = total_q + 32'd1;
      hit_cnt_d  = hit ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = hit ? miss_cnt_q : miss_cnt_q + 32'd1;
      ovalid_d   = 1'b1;
      l1miss_d   = !hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAY_COUNT; w++) age_q[s][w] <= way_t'(w);
      end
      lfsr_q     <= 8'hA5;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      total_q    <= '0;
      l1miss_q   <= 1'b0;
      ovalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      age_q      <= age_d;
      lfsr_q     <= lfsr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      total_q    <= total_d;
      l1miss_q   <= l1miss_d;
      ovalid_q   <= ovalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign L1miss         = l1miss_q;
  assign ovalid         = ovalid_q;
  assign oread_data     = rdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;
  assign total_accesses = total_q;

endmodule

// File: tb/tb_multi_cache.sv
// Bench for multi_cache: a 2-way LRU and a 4-way random instance share one stimulus stream and
// are scored against a timestamp-LRU / LFSR reference model through expected-response queues.
module tb_multi_cache;

  localparam int EW = 105;  // {miss, data[7:0], hits[31:0], misses[31:0], total[31:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, ivalid = 1'b0, iRW = 1'b0;
  logic [10:0]     iaddress = '0;
  logic [31:0][7:0] iRAM32 = '0;
  logic [7:0]      iwrite_data = '0;

  logic        l_miss, l_ovalid, r_miss, r_ovalid;
  logic [7:0]  l_rdata, r_rdata;
  logic [31:0] l_hits, l_misses, l_total, r_hits, r_misses, r_total;

  multi_cache #(.WAY_COUNT(2), .USE_RANDOM_REPLACEMENT(1'b0)) u_lru (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iRW(iRW), .iaddress(iaddress), .iRAM32(iRAM32),
    .iwrite_data(iwrite_data), .L1miss(l_miss), .ovalid(l_ovalid), .oread_data(l_rdata),
    .hit_count(l_hits), .miss_count(l_misses), .total_accesses(l_total));

  multi_cache #(.WAY_COUNT(4), .USE_RANDOM_REPLACEMENT(1'b1)) u_rnd (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iRW(iRW), .iaddress(iaddress), .iRAM32(iRAM32),
    .iwrite_data(iwrite_data), .L1miss(r_miss), .ovalid(r_ovalid), .oread_data(r_rdata),
    .hit_count(r_hits), .miss_count(r_misses), .total_accesses(r_total));

  int checks = 0, errors = 0;
  bit started = 1'b0;

  // Reference model: backing memory plus per-instance line state with use timestamps.
  logic [7:0]  mem [2048];
  bit          mvalid [2][8][4];
  logic [2:0]  mtag   [2][8][4];
  logic [7:0]  mdata  [2][8][4][32];
  int          mstamp [2][8][4];
  int          stamp = 0;
  logic [31:0] mhits [2], mmisses [2];
  logic [7:0]  m_lfsr;
  logic        last_miss [2];
  logic [7:0]  last_data [2];
  logic [EW-1:0] exp_l_q[$], exp_r_q[$];

  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int m, input logic rw, input logic [10:0] a, input logic [7:0] wd);
    int s = int'(a[7:5]);
    int o = int'(a[4:0]);
    int nw = (m == 0) ? 2 : 4;
    int way = -1;
    int best;
    bit miss;
    logic [7:0] d;
    for (int w = 0; w < nw; w++)
      if (mvalid[m][s][w] && mtag[m][s][w] == a[10:8]) way = w;
    miss = (way < 0);
    if (miss) begin
      for (int w = nw - 1; w >= 0; w--) if (!mvalid[m][s][w]) way = w;
      if (way < 0) begin
        if (m == 0) begin
          best = 0;
          for (int w = 1; w < nw; w++) if (mstamp[m][s][w] < mstamp[m][s][best]) best = w;
          way = best;
        end else begin
          way = int'(m_lfsr) % nw;
        end
      end
      mvalid[m][s][way] = 1'b1;
      mtag[m][s][way]   = a[10:8];
      for (int k = 0; k < 32; k++) mdata[m][s][way][k] = mem[{a[10:5], 5'(k)}];
    end
    stamp++;
    mstamp[m][s][way] = stamp;
    if (rw) begin
      mdata[m][s][way][o] = wd;
      d = wd;
    end else begin
      d = mdata[m][s][way][o];
    end
    if (miss) mmisses[m]++; else mhits[m]++;
    if (m == 0) exp_l_q.push_back({miss, d, mhits[m], mmisses[m], mhits[m] + mmisses[m]});
    else        exp_r_q.push_back({miss, d, mhits[m], mmisses[m], mhits[m] + mmisses[m]});
  endtask

  task automatic check_out(input int m, input logic ov, input logic miss, input logic [7:0] d,
                           input logic [31:0] h, input logic [31:0] mi, input logic [31:0] t);
    logic [EW-1:0] e;
    string p = (m == 0) ? "lru" : "rnd";
    if (ov) begin
      if ((m == 0) ? (exp_l_q.size() == 0) : (exp_r_q.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_ovalid: got ovalid=1 expected 0 at %0t", p, $time);
      end else begin
        e = (m == 0) ? exp_l_q.pop_front() : exp_r_q.pop_front();
        check({p, "_l1miss"}, 32'(miss), 32'(e[104]));
        check({p, "_data"}, 32'(d), 32'(e[103:96]));
        check({p, "_hits"}, h, e[95:64]);
        check({p, "_misses"}, mi, e[63:32]);
        check({p, "_total"}, t, e[31:0]);
        last_miss[m] = e[104];
        last_data[m] = e[103:96];
      end
    end else begin
      check({p, "_hold_l1miss"}, 32'(miss), 32'(last_miss[m]));
      check({p, "_hold_data"}, 32'(d), 32'(last_data[m]));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_out(0, l_ovalid, l_miss, l_rdata, l_hits, l_misses, l_total);
      check_out(1, r_ovalid, r_miss, r_rdata, r_hits, r_misses, r_total);
    end
  end

  // Reset with a pending request on the inputs: that request must be discarded.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ivalid = 1'b1;
    iRW = 1'($urandom);
    iaddress = 11'($urandom);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 8; s++) for (int w = 0; w < 4; w++) mvalid[m][s][w] = 1'b0;
      mhits[m] = '0;
      mmisses[m] = '0;
      last_miss[m] = 1'b0;
      last_data[m] = '0;
    end
    started = 1'b1;
    @(negedge clk);
    check("lru_rst_ovalid", 32'(l_ovalid), 32'd0);
    check("lru_rst_total", l_total, 32'd0);
    check("rnd_rst_ovalid", 32'(r_ovalid), 32'd0);
    check("rnd_rst_total", r_total, 32'd0);
    rst = 1'b0;
    ivalid = 1'b0;
  endtask

  task automatic do_access(input logic rw, input logic [10:0] a, input logic [7:0] wd);
    @(negedge clk);
    rst = 1'b0;
    ivalid = 1'b1;
    iRW = rw;
    iaddress = a;
    iwrite_data = wd;
    for (int k = 0; k < 32; k++) iRAM32[k] = mem[{a[10:5], 5'(k)}];
    model(0, rw, a, wd);
    model(1, rw, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ivalid = 1'b0;
      iRW = 1'($urandom);
      iaddress = 11'($urandom);
      iwrite_data = 8'($urandom);
      for (int k = 0; k < 32; k++) iRAM32[k] = 8'($urandom);
    end
  endtask

  initial begin
    int r;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 32; k++) mem[11'h120 + k] = 8'hC0 + 8'(k);

    do_reset();
    do_access(1'b0, 11'h120, 8'h00);
    idle(2);

    do_reset();
    do_access(1'b0, 11'h120, 8'h00);
    do_access(1'b0, 11'h121, 8'h00);
    idle(2);

    do_reset();
    do_access(1'b0, 11'h120, 8'h00);
    do_access(1'b0, 11'h220, 8'h00);
    do_access(1'b0, 11'h320, 8'h00);
    do_access(1'b0, 11'h420, 8'h00);
    do_access(1'b0, 11'h120, 8'h00);
    do_access(1'b0, 11'h220, 8'h00);
    idle(2);

    do_reset();
    do_access(1'b1, 11'h125, 8'h5A);
    do_access(1'b0, 11'h125, 8'h00);
    idle(1);

    do_access(1'b0, 11'h300, 8'h00);
    do_access(1'b1, 11'h301, 8'h11);
    do_reset();
    do_access(1'b0, 11'h120, 8'h00);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 15) begin
        idle($urandom_range(1, 3));
      end else begin
        if (r < 22) mem[$urandom_range(0, 2047)] = 8'($urandom);
        a = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 5'($urandom)};
        do_access(($urandom_range(0, 99) < 30), a, 8'($urandom));
      end
    end
    idle(3);

    check("lru_queue_drained", 32'(exp_l_q.size()), 32'd0);
    check("rnd_queue_drained", 32'(exp_r_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
